// File: rtl/sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sobel_frame_ctrl
// Brief    : Per-frame sequencer that resets, feeds and tracks the Sobel
//            3-line buffer, tagging each emitted 3x3 window with coordinates.
// Revision : 1.0  initial release
// ============================================================================
module sobel_frame_ctrl #(
    parameter int MAX_WIDTH     = 1920,
    parameter int MAX_HEIGHT    = 1080,
    parameter int LB_RST_CYCLES = 2,
    parameter int DRAIN_TIMEOUT = 4096
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic        abort,
    input  logic [10:0] cfg_width,
    input  logic [10:0] cfg_height,
    output logic        busy,
    output logic        frame_done,
    output logic        cfg_err,
    output logic        timeout_err,
    input  logic        src_valid,
    input  logic [7:0]  src_data,
    output logic        src_ready,
    output logic        lb_rst_n,
    output logic        lb_enable,
    output logic        lb_valid_in,
    output logic [7:0]  lb_data_in,
    output logic [10:0] lb_image_width,
    output logic [10:0] lb_image_height,
    input  logic        lb_valid_out,
    output logic        win_valid,
    output logic [10:0] win_x,
    output logic [10:0] win_y,
    output logic        win_first,
    output logic        win_last
);

    localparam int c_to_w  = $clog2(DRAIN_TIMEOUT) + 1;
    localparam int c_rst_w = (LB_RST_CYCLES > 1) ? $clog2(LB_RST_CYCLES) : 1;

    localparam logic [c_to_w-1:0]  c_to_max   = c_to_w'(DRAIN_TIMEOUT);
    localparam logic [c_rst_w-1:0] c_rst_last = c_rst_w'(LB_RST_CYCLES - 1);
    localparam logic [10:0]        c_max_w    = 11'(MAX_WIDTH);
    localparam logic [10:0]        c_max_h    = 11'(MAX_HEIGHT);

    localparam logic [2:0] c_s_idle   = 3'd0;
    localparam logic [2:0] c_s_lbrst  = 3'd1;
    localparam logic [2:0] c_s_stream = 3'd2;
    localparam logic [2:0] c_s_drain  = 3'd3;
    localparam logic [2:0] c_s_done   = 3'd4;

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic [10:0]        r_width;
    logic [10:0]        r_height;
    logic [10:0]        r_in_x;
    logic [10:0]        r_in_y;
    logic [10:0]        r_win_x;
    logic [10:0]        r_win_y;
    logic [c_to_w-1:0]  r_to_cnt;
    logic [c_rst_w-1:0] r_rst_cnt;
    logic               r_cfg_err;
    logic               r_abort_rst;
    logic               r_live;

    logic w_busy;
    logic w_idle;
    logic w_streaming;
    logic w_tracking;
    logic w_geom_ok;
    logic w_accept;
    logic w_in_x_end;
    logic w_in_y_end;
    logic w_last_pixel;
    logic w_win_valid;
    logic w_win_x_end;
    logic w_win_y_end;
    logic w_win_last;
    logic w_timeout;
    logic w_rst_end;

    assign w_idle       = (r_state == c_s_idle);
    assign w_busy       = ~w_idle;
    assign w_streaming  = (r_state == c_s_stream);
    assign w_tracking   = w_streaming | (r_state == c_s_drain);
    assign w_geom_ok    = (cfg_width  >= 11'd3) && (cfg_width  <= c_max_w) &&
                          (cfg_height >= 11'd3) && (cfg_height <= c_max_h);
    assign w_accept     = src_valid & w_streaming;
    assign w_in_x_end   = (r_in_x == r_width  - 11'd1);
    assign w_in_y_end   = (r_in_y == r_height - 11'd1);
    assign w_last_pixel = w_accept & w_in_x_end & w_in_y_end;
    assign w_win_valid  = lb_valid_out & w_tracking;
    assign w_win_x_end  = (r_win_x == r_width  - 11'd1);
    assign w_win_y_end  = (r_win_y == r_height - 11'd1);
    assign w_win_last   = w_win_valid & w_win_x_end & w_win_y_end;
    assign w_timeout    = (r_state == c_s_drain) & ~w_win_valid & (r_to_cnt == c_to_max);
    assign w_rst_end    = (r_rst_cnt == c_rst_last);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_s_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // abort outranks every other transition out of a busy state
    always_comb begin
        w_state_nxt = r_state;
        if (abort && w_busy) begin
            w_state_nxt = c_s_idle;
        end else begin
            case (r_state)
                c_s_idle:   if (start && w_geom_ok) w_state_nxt = c_s_lbrst;
                c_s_lbrst:  if (w_rst_end) w_state_nxt = c_s_stream;
                c_s_stream: begin
                    if (w_win_last)        w_state_nxt = c_s_done;
                    else if (w_last_pixel) w_state_nxt = c_s_drain;
                end
                c_s_drain: begin
                    if (w_win_last)     w_state_nxt = c_s_done;
                    else if (w_timeout) w_state_nxt = c_s_idle;
                end
                c_s_done:   w_state_nxt = c_s_idle;
                default:    w_state_nxt = c_s_idle;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_width     <= '0;
            r_height    <= '0;
            r_in_x      <= '0;
            r_in_y      <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
            r_to_cnt    <= '0;
            r_rst_cnt   <= '0;
            r_cfg_err   <= 1'b0;
            r_abort_rst <= 1'b0;
            r_live      <= 1'b0;
        end else begin
            r_live      <= 1'b1;
            r_cfg_err   <= w_idle & start & ~w_geom_ok;
            r_abort_rst <= abort & w_busy;

            if (w_idle && start && w_geom_ok) begin
                r_width  <= cfg_width;
                r_height <= cfg_height;
            end

            if (r_state == c_s_lbrst) r_rst_cnt <= r_rst_cnt + 1'b1;
            else                      r_rst_cnt <= '0;

            if (r_state == c_s_lbrst) begin
                r_in_x <= '0;
                r_in_y <= '0;
            end else if (w_accept) begin
                if (w_in_x_end) begin
                    r_in_x <= '0;
                    r_in_y <= w_in_y_end ? 11'd0 : r_in_y + 11'd1;
                end else begin
                    r_in_x <= r_in_x + 11'd1;
                end
            end

            if (r_state == c_s_lbrst) begin
                r_win_x <= '0;
                r_win_y <= '0;
            end else if (w_win_valid) begin
                if (w_win_x_end) begin
                    r_win_x <= '0;
                    r_win_y <= w_win_y_end ? 11'd0 : r_win_y + 11'd1;
                end else begin
                    r_win_x <= r_win_x + 11'd1;
                end
            end

            // saturates at the limit so the timeout condition holds until taken
            if (r_state == c_s_drain) begin
                if (w_win_valid)             r_to_cnt <= '0;
                else if (r_to_cnt != c_to_max) r_to_cnt <= r_to_cnt + 1'b1;
            end else begin
                r_to_cnt <= '0;
            end
        end
    end

    assign busy            = w_busy;
    assign frame_done      = (r_state == c_s_done) & ~abort;
    assign cfg_err         = r_cfg_err;
    assign timeout_err     = w_timeout & ~abort;
    assign src_ready       = w_streaming;
    assign lb_rst_n        = r_live & (r_state != c_s_lbrst) & ~r_abort_rst;
    assign lb_enable       = w_tracking;
    assign lb_valid_in     = w_accept;
    assign lb_data_in      = src_data;
    assign lb_image_width  = r_width;
    assign lb_image_height = r_height;
    assign win_valid       = w_win_valid;
    assign win_x           = r_win_x;
    assign win_y           = r_win_y;
    assign win_first       = w_win_valid & (r_win_x == 11'd0) & (r_win_y == 11'd0);
    assign win_last        = w_win_last;

endmodule
`default_nettype wire

// File: tb/tb_sobel_frame_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sobel_frame_ctrl
// Brief    : Directed/random bench for sobel_frame_ctrl with a delay-line line
//            buffer model and an ordinal-based window reference.
// Revision : 1.0  initial release
// ============================================================================
module tb_sobel_frame_ctrl;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [10:0] cfg_width = '0;
    logic [10:0] cfg_height = '0;
    logic        src_valid = 1'b0;
    logic [7:0]  src_data = '0;
    logic        lb_valid_out = 1'b0;
    logic        busy, frame_done, cfg_err, timeout_err, src_ready;
    logic        lb_rst_n, lb_enable, lb_valid_in;
    logic [7:0]  lb_data_in;
    logic [10:0] lb_image_width, lb_image_height;
    logic        win_valid, win_first, win_last;
    logic [10:0] win_x, win_y;

    sobel_frame_ctrl dut (
        .clk(clk), .reset_n(reset_n), .start(start), .abort(abort),
        .cfg_width(cfg_width), .cfg_height(cfg_height),
        .busy(busy), .frame_done(frame_done), .cfg_err(cfg_err), .timeout_err(timeout_err),
        .src_valid(src_valid), .src_data(src_data), .src_ready(src_ready),
        .lb_rst_n(lb_rst_n), .lb_enable(lb_enable), .lb_valid_in(lb_valid_in),
        .lb_data_in(lb_data_in), .lb_image_width(lb_image_width),
        .lb_image_height(lb_image_height), .lb_valid_out(lb_valid_out),
        .win_valid(win_valid), .win_x(win_x), .win_y(win_y),
        .win_first(win_first), .win_last(win_last)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int fw, fh, hs, wk, rst_low, done_cnt, to_cnt, win_limit, win_emit;
    int cyc, last_hs_cyc, to_cyc;
    bit frame_on, busy_s, prev_done;
    bit [2:0] dl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // line buffer stand-in: one window per written pixel, three cycles later
    task automatic sample();
        if (!lb_rst_n) rst_low++;
        if (frame_done) begin
            done_cnt++;
            chk("busy_at_done", busy, 1);
        end
        if (prev_done) chk("busy_after_done", busy, 0);
        prev_done = frame_done;
        if (timeout_err) begin
            to_cnt++;
            to_cyc = cyc;
        end
        if (lb_valid_in) begin
            chk("lb_data", lb_data_in, src_data);
            hs++;
            last_hs_cyc = cyc;
        end else if (frame_on && hs == fw * fh) begin
            chk("src_ready_drop", src_ready, 0);
        end
        if (win_valid) begin
            chk("win_x", win_x, wk % fw);
            chk("win_y", win_y, wk / fw);
            chk("win_first", win_first, (wk == 0) ? 1 : 0);
            chk("win_last", win_last, (wk == fw * fh - 1) ? 1 : 0);
            wk++;
        end
        busy_s = busy;
        if (!lb_rst_n) dl = '0;
        else           dl = {dl[1:0], lb_valid_in};
        cyc++;
    endtask

    task automatic tick();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        lb_valid_out = dl[2] && (win_emit < win_limit);
        if (lb_valid_out) win_emit++;
    endtask

    task automatic new_frame(input int w, input int h, input int limit);
        fw = w; fh = h; hs = 0; wk = 0; rst_low = 0; done_cnt = 0; to_cnt = 0;
        win_limit = limit; win_emit = 0; frame_on = 1'b1; prev_done = 1'b0;
        cfg_width = 11'(w); cfg_height = 11'(h);
    endtask

    task automatic issue_start();
        start = 1'b1;
        src_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic run_to_idle(input int pct, input int bound);
        int n = 0;
        while (n < bound) begin
            src_valid = ($urandom_range(0, 99) < pct);
            src_data  = 8'($urandom);
            tick();
            n++;
            if (!busy_s) break;
        end
        chk("frame_within_bound", (n < bound) ? 1 : 0, 1);
        src_valid = 1'b0;
        frame_on  = 1'b0;
    endtask

    task automatic run_until_hs(input int target);
        int n = 0;
        while (hs < target && n < 200) begin
            src_valid = 1'b1;
            src_data  = 8'($urandom);
            tick();
            n++;
        end
        chk("reach_pixel_count", hs, target);
    endtask

    task automatic good_frame(input string tag, input int w, input int h, input int pct);
        new_frame(w, h, 1 << 30);
        issue_start();
        run_to_idle(pct, 2000);
        chk({tag, "_lb_rst_low"}, rst_low, 2);
        chk({tag, "_strobes"}, hs, w * h);
        chk({tag, "_windows"}, wk, w * h);
        chk({tag, "_frame_done"}, done_cnt, 1);
        chk({tag, "_timeout"}, to_cnt, 0);
        chk({tag, "_lat_w"}, lb_image_width, w);
        chk({tag, "_lat_h"}, lb_image_height, h);
    endtask

    task automatic bad_start(input string tag, input int w, input int h);
        cfg_width = 11'(w); cfg_height = 11'(h);
        frame_on = 1'b0;
        issue_start();
        chk({tag, "_cfg_err"}, cfg_err, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_src_ready"}, src_ready, 0);
        chk({tag, "_keep_w"}, lb_image_width, fw);
        chk({tag, "_keep_h"}, lb_image_height, fh);
        tick();
        chk({tag, "_cfg_err_1cyc"}, cfg_err, 0);
        chk({tag, "_busy_after"}, busy, 0);
    endtask

    initial begin
        dl = '0; cyc = 0; frame_on = 1'b0; fw = 1; fh = 1; win_limit = 0; win_emit = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_lb_rst_n", lb_rst_n, 0);
        chk("rst_src_ready", src_ready, 0);
        chk("rst_lb_enable", lb_enable, 0);
        chk("rst_width", lb_image_width, 0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        tick();
        chk("idle_lb_rst_n", lb_rst_n, 1);

        // asynchronous reset in the middle of streaming
        new_frame(8, 4, 1 << 30);
        issue_start();
        run_until_hs(10);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_src_ready", src_ready, 0);
        chk("arst_lb_valid_in", lb_valid_in, 0);
        chk("arst_lb_enable", lb_enable, 0);
        chk("arst_lb_rst_n", lb_rst_n, 0);
        chk("arst_width", lb_image_width, 0);
        chk("arst_height", lb_image_height, 0);
        chk("arst_win_valid", win_valid, 0);
        frame_on = 1'b0; src_valid = 1'b0; dl = '0; lb_valid_out = 1'b0;
        tick();
        #2 reset_n = 1'b1;
        tick();

        good_frame("cont8x4", 8, 4, 100);
        bad_start("w2", 2, 4);
        bad_start("w1921", 1921, 4);
        bad_start("h1081", 8, 1081);
        good_frame("rand8x4", 8, 4, 50);
        good_frame("rand3x3", 3, 3, 50);

        // windows stop after 20: drain must time out
        new_frame(8, 4, 20);
        issue_start();
        run_to_idle(100, 6000);
        chk("to_pulse", to_cnt, 1);
        chk("to_no_done", done_cnt, 0);
        chk("to_windows", wk, 20);
        chk("to_latency", ((to_cyc - last_hs_cyc) >= 4096 && (to_cyc - last_hs_cyc) <= 4098) ? 1 : 0, 1);
        chk("to_idle", busy, 0);

        // abort together with a (legal) start while streaming
        new_frame(8, 4, 1 << 30);
        issue_start();
        run_until_hs(5);
        abort = 1'b1; start = 1'b1; cfg_width = 11'd5; cfg_height = 11'd5;
        src_valid = 1'b1;
        tick();
        abort = 1'b0; start = 1'b0; src_valid = 1'b0;
        chk("abort_idle", busy, 0);
        chk("abort_lb_rst_n", lb_rst_n, 0);
        chk("abort_keep_w", lb_image_width, 8);
        tick();
        chk("abort_lb_rst_1cyc", lb_rst_n, 1);
        chk("abort_start_ignored", busy, 0);
        repeat (4) tick();
        chk("abort_no_done", done_cnt, 0);
        frame_on = 1'b0;

        good_frame("post_abort6x5", 6, 5, 50);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
